// File: rtl/uart_tx_arb_if.sv
// Byte-stream bundle between NREQ requesters, the arbiter and the UART TX byte port.
// master drives requester bytes and tx_ready; slave is the arbiter side.
interface uart_tx_arb_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX byte port among NREQ requesters.
// A grant covers a whole burst, bounded by a byte cap and a stall timeout, then an idle gap.
module uart_tx_arb #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned GAP_CYC   = 16,
   parameter int unsigned LOCK_MAX  = 255,
   parameter int unsigned STALL_MAX = 64
) (
   input  logic                    app_clk,
   input  logic                    reset_n,
   input  logic                    cfg_arb_en,
   uart_tx_arb_if.slave            bus,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    stall_abort
);

   localparam int unsigned IdxW      = $clog2(NREQ);
   localparam logic [7:0]  LockLast  = 8'(LOCK_MAX - 1);
   localparam logic [7:0]  StallLast = 8'(STALL_MAX - 1);
   localparam logic [7:0]  GapLast   = 8'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

   state_e          state_q;
   logic [IdxW-1:0] grant_q, rr_q;
   logic [7:0]      byte_cnt_q, gap_cnt_q, stall_cnt_q;
   logic            busy_q, abort_q;

   logic [7:0]      req_byte [NREQ];
   logic [IdxW-1:0] sel, sel_idx;
   logic            sel_vld;
   int unsigned     rr_idx;
   logic            in_xfer, own_vld, own_last, hs;
   logic            burst_end, stall_hit, xfer_exit;

   for (genvar i = 0; i < NREQ; i++) begin : g_byte
      assign req_byte[i] = bus.req_data[8*i +: 8];
   end

   // Search starts just after the last winner; wrap is explicit so NREQ need not be 2^n.
   always_comb begin
      sel_vld = 1'b0;
      sel     = rr_q;
      sel_idx = '0;
      rr_idx  = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         rr_idx = 32'(rr_q) + k;
         if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
         sel_idx = IdxW'(rr_idx);
         if (!sel_vld && bus.req_valid[sel_idx]) begin
            sel_vld = 1'b1;
            sel     = sel_idx;
         end
      end
   end

   assign in_xfer      = (state_q == StXfer);
   assign own_vld      = bus.req_valid[grant_q];
   assign own_last     = bus.req_last[grant_q];
   assign bus.tx_valid = in_xfer & own_vld & cfg_arb_en;
   assign bus.tx_data  = in_xfer ? req_byte[grant_q] : 8'h00;
   assign hs           = bus.tx_valid & bus.tx_ready;

   always_comb begin
      bus.req_ready = '0;
      if (in_xfer) bus.req_ready[grant_q] = bus.tx_ready & cfg_arb_en;
   end

   // A stall hit implies no handshake, so the abort pulse never coincides with a transfer.
   assign burst_end = hs & (own_last | (byte_cnt_q == LockLast));
   assign stall_hit = cfg_arb_en & ~own_vld & (stall_cnt_q == StallLast);
   assign xfer_exit = ~cfg_arb_en | burst_end | stall_hit;

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_q        <= IdxW'(NREQ - 1);
         byte_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         stall_cnt_q <= '0;
         busy_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cfg_arb_en && sel_vld) begin
                  grant_q     <= sel;
                  rr_q        <= sel;
                  byte_cnt_q  <= '0;
                  stall_cnt_q <= '0;
                  state_q     <= StXfer;
                  busy_q      <= 1'b1;
               end
            end
            StXfer: begin
               if (hs) begin
                  if (byte_cnt_q != LockLast) byte_cnt_q <= byte_cnt_q + 8'd1;
                  stall_cnt_q <= '0;
               end else if (!own_vld) begin
                  if (stall_cnt_q != StallLast) stall_cnt_q <= stall_cnt_q + 8'd1;
               end else begin
                  stall_cnt_q <= '0;
               end
               if (xfer_exit) begin
                  abort_q   <= stall_hit;
                  gap_cnt_q <= '0;
                  if (GAP_CYC == 0) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StGap;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign stall_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: vector table, directed burst scenarios and a random run
// checked every cycle against a transaction-level reference model.
module tb_uart_tx_arb;

   localparam int NREQ  = 4;
   localparam int GAP   = 16;
   localparam int LOCK  = 4;
   localparam int STALL = 64;

   logic       app_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_arb_en = 1'b0;
   logic [1:0] grant_id;
   logic       busy, stall_abort;

   uart_tx_arb_if #(.NREQ(NREQ)) bus ();

   uart_tx_arb #(
      .NREQ     (NREQ),
      .GAP_CYC  (GAP),
      .LOCK_MAX (LOCK),
      .STALL_MAX(STALL)
   ) dut (
      .app_clk    (app_clk),
      .reset_n    (reset_n),
      .cfg_arb_en (cfg_arb_en),
      .bus        (bus),
      .grant_id   (grant_id),
      .busy       (busy),
      .stall_abort(stall_abort)
   );

   always #5 app_clk = ~app_clk;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;
   int abort_cnt = 0;
   int drv_mode = 0;  // 0 manual, 1 source queues, 2 random

   logic [8:0] src_mem [NREQ][64];
   int         src_hd [NREQ];
   int         src_tl [NREQ];
   int         hs_own [$];
   int         hs_dat [$];
   int         hs_cyc [$];

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       etv;
      logic [7:0] etd;
      logic [3:0] erdy;
      logic       ebusy;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic tick();
      @(posedge app_clk);
      #1;
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      src_mem[r][src_tl[r]] = {l, d};
      src_tl[r]++;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      drv_mode      = 0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_ready  = 1'b1;
      cfg_arb_en    = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         src_hd[i] = 0;
         src_tl[i] = 0;
      end
      hs_own.delete();
      hs_dat.delete();
      hs_cyc.delete();
      abort_cnt = 0;
      repeat (2) @(posedge app_clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_hs(input int n, input int budget);
      int b;
      b = budget;
      while (hs_own.size() < n && b > 0) begin
         tick();
         b--;
      end
      chk("wait_handshakes", hs_own.size(), n);
   endtask

   always @(posedge app_clk) cyc_n++;

   // Input driver: queued sources or random traffic, settled well before the sampling edge.
   always @(posedge app_clk) begin
      #2;
      if (drv_mode == 1) begin
         for (int i = 0; i < NREQ; i++) begin
            if (src_hd[i] != src_tl[i]) begin
               bus.req_valid[i]       = 1'b1;
               bus.req_data[8*i +: 8] = src_mem[i][src_hd[i]][7:0];
               bus.req_last[i]        = src_mem[i][src_hd[i]][8];
            end else begin
               bus.req_valid[i] = 1'b0;
               bus.req_last[i]  = 1'b0;
            end
         end
      end else if (drv_mode == 2) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(7) == 0) bus.req_valid[i] = ~bus.req_valid[i];
            bus.req_data[8*i +: 8] = 8'($urandom_range(255));
            bus.req_last[i]        = ($urandom_range(3) == 0);
         end
         bus.tx_ready = ($urandom_range(3) != 0);
         if ($urandom_range(199) == 0) cfg_arb_en = ~cfg_arb_en;
      end
   end

   // Handshake log and source pops.
   always @(negedge app_clk) begin
      if (reset_n) begin
         if (bus.tx_valid && bus.tx_ready) begin
            hs_own.push_back(int'(grant_id));
            hs_dat.push_back(int'(bus.tx_data));
            hs_cyc.push_back(cyc_n);
         end
         if (stall_abort) abort_cnt++;
         if (drv_mode == 1) begin
            for (int i = 0; i < NREQ; i++) begin
               if (bus.req_valid[i] && bus.req_ready[i] && src_hd[i] != src_tl[i]) src_hd[i]++;
            end
         end
      end
   end

   // Reference model: owner, bytes sent, length of the current idle run, gap cycles left.
   localparam int MIdle = 0, MXfer = 1, MGap = 2;
   int   m_mode, m_own, m_rr, m_bytes, m_low, m_gap;
   logic m_abort;

   always @(negedge app_clk) begin
      logic [NREQ-1:0] e_rdy;
      logic            e_tv;
      bit              done, found;
      if (!reset_n) begin
         m_mode = MIdle; m_own = 0; m_rr = NREQ - 1;
         m_bytes = 0; m_low = 0; m_gap = 0; m_abort = 1'b0;
         chk("rst_tx_valid", bus.tx_valid, 0);
         chk("rst_tx_data", bus.tx_data, 0);
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_grant_id", grant_id, 0);
         chk("rst_busy", busy, 0);
         chk("rst_stall_abort", stall_abort, 0);
      end else begin
         e_tv  = (m_mode == MXfer) && cfg_arb_en && bus.req_valid[m_own];
         e_rdy = '0;
         if (m_mode == MXfer && cfg_arb_en && bus.tx_ready) e_rdy[m_own] = 1'b1;
         chk("model_tx_valid", bus.tx_valid, e_tv);
         if (m_mode == MXfer) chk("model_tx_data", bus.tx_data, bus.req_data[8*m_own +: 8]);
         chk("model_req_ready", bus.req_ready, e_rdy);
         chk("model_grant_id", grant_id, m_own);
         chk("model_busy", busy, m_mode != MIdle);
         chk("model_stall_abort", stall_abort, m_abort);
         m_abort = 1'b0;
         case (m_mode)
            MIdle: begin
               if (cfg_arb_en && (bus.req_valid != '0)) begin
                  found = 0;
                  for (int k = 1; k <= NREQ; k++) begin
                     if (!found && bus.req_valid[(m_rr + k) % NREQ]) begin
                        found = 1;
                        m_own = (m_rr + k) % NREQ;
                     end
                  end
                  m_rr = m_own; m_bytes = 0; m_low = 0; m_mode = MXfer;
               end
            end
            MXfer: begin
               done = 0;
               if (!cfg_arb_en) done = 1;
               else if (bus.req_valid[m_own] && bus.tx_ready) begin
                  m_bytes++;
                  m_low = 0;
                  if (bus.req_last[m_own] || m_bytes >= LOCK) done = 1;
               end else if (!bus.req_valid[m_own]) begin
                  m_low++;
                  if (m_low >= STALL) begin
                     done = 1;
                     m_abort = 1'b1;
                  end
               end else m_low = 0;
               if (done) begin
                  m_mode = (GAP == 0) ? MIdle : MGap;
                  m_gap  = GAP;
               end
            end
            default: begin
               m_gap--;
               if (m_gap == 0) m_mode = MIdle;
            end
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [6];

      // Single source, table driven: 41,42,43 back to back one cycle after valid rises.
      tbl[0] = '{v:0, d:8'h00, l:0, etv:0, etd:8'h00, erdy:4'h0, ebusy:0};
      tbl[1] = '{v:1, d:8'h41, l:0, etv:0, etd:8'h00, erdy:4'h0, ebusy:0};
      tbl[2] = '{v:1, d:8'h41, l:0, etv:1, etd:8'h41, erdy:4'h1, ebusy:1};
      tbl[3] = '{v:1, d:8'h42, l:0, etv:1, etd:8'h42, erdy:4'h1, ebusy:1};
      tbl[4] = '{v:1, d:8'h43, l:1, etv:1, etd:8'h43, erdy:4'h1, ebusy:1};
      tbl[5] = '{v:0, d:8'h00, l:0, etv:0, etd:8'h00, erdy:4'h0, ebusy:1};
      do_reset();
      for (int r = 0; r < 6; r++) begin
         bus.req_valid = {3'b000, tbl[r].v};
         bus.req_data  = {24'h0, tbl[r].d};
         bus.req_last  = {3'b000, tbl[r].l};
         @(negedge app_clk);
         chk("tbl_tx_valid", bus.tx_valid, tbl[r].etv);
         if (tbl[r].etv) chk("tbl_tx_data", bus.tx_data, tbl[r].etd);
         chk("tbl_req_ready", bus.req_ready, tbl[r].erdy);
         chk("tbl_busy", busy, tbl[r].ebusy);
         chk("tbl_grant_id", grant_id, 0);
         tick();
      end
      for (int i = 0; i <= 15; i++) begin
         @(negedge app_clk);
         chk("gap_busy", busy, i < GAP - 1);
         tick();
      end

      // Round robin: every source holds two 2-byte bursts.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         for (int k = 0; k < 4; k++) push(i, 8'(16 * i + k), k[0]);
      end
      drv_mode = 1;
      wait_hs(16, 400);
      for (int j = 0; j < 16 && j < hs_own.size(); j++) begin
         chk("rr_owner", hs_own[j], (j / 2) % 4);
         chk("rr_data", hs_dat[j], 16 * ((j / 2) % 4) + (j / 8) * 2 + j % 2);
      end

      // Lock cap: a lone 10-byte stream is cut into 4, 4, 2 with a full gap between.
      do_reset();
      for (int k = 0; k < 10; k++) push(2, 8'(8'hA0 + k), 1'b0);
      drv_mode = 1;
      wait_hs(10, 200);
      for (int j = 0; j < 10 && j < hs_own.size(); j++) begin
         chk("lock_owner", hs_own[j], 2);
         chk("lock_data", hs_dat[j], 8'hA0 + j);
         if (j > 0) chk("lock_spacing", hs_cyc[j] - hs_cyc[j-1], (j % 4 == 0) ? GAP + 2 : 1);
      end

      // Stall abort: req1 goes silent after one byte, pending req3 follows the gap.
      do_reset();
      push(1, 8'h55, 1'b0);
      push(3, 8'h71, 1'b0);
      push(3, 8'h72, 1'b1);
      drv_mode = 1;
      wait_hs(3, 200);
      if (hs_own.size() >= 3) begin
         chk("stall_owner0", hs_own[0], 1);
         chk("stall_owner1", hs_own[1], 3);
         chk("stall_data2", hs_dat[2], 8'h72);
         chk("stall_spacing", hs_cyc[1] - hs_cyc[0], STALL + GAP + 2);
      end
      chk("stall_abort_count", abort_cnt, 1);

      // Backpressure: tx_ready low for 20 cycles after the first byte.
      do_reset();
      push(0, 8'h31, 1'b0);
      push(0, 8'h32, 1'b0);
      push(0, 8'h33, 1'b1);
      drv_mode = 1;
      wait_hs(1, 50);
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge app_clk);
         chk("bp_tx_data", bus.tx_data, 8'h32);
         chk("bp_tx_valid", bus.tx_valid, 1);
         chk("bp_req_ready", bus.req_ready, 0);
         tick();
      end
      bus.tx_ready = 1'b1;
      wait_hs(3, 50);
      for (int j = 0; j < 3 && j < hs_own.size(); j++) begin
         chk("bp_owner", hs_own[j], 0);
         chk("bp_data", hs_dat[j], 8'h31 + j);
      end
      chk("bp_no_abort", abort_cnt, 0);

      // Asynchronous reset in the middle of a req2 burst clears outputs at once.
      do_reset();
      for (int k = 0; k < 4; k++) push(2, 8'(8'h61 + k), k == 3);
      drv_mode = 1;
      wait_hs(1, 50);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_tx_valid", bus.tx_valid, 0);
      chk("arst_tx_data", bus.tx_data, 0);
      chk("arst_req_ready", bus.req_ready, 0);
      chk("arst_grant_id", grant_id, 0);
      chk("arst_busy", busy, 0);
      drv_mode = 0;

      // Enable dropped mid-burst: gap, idle, no regrant until re-enabled.
      do_reset();
      for (int k = 0; k < 4; k++) push(0, 8'(8'h81 + k), k == 3);
      drv_mode = 1;
      wait_hs(1, 50);
      cfg_arb_en = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge app_clk);
         chk("dis_tx_valid", bus.tx_valid, 0);
         chk("dis_busy", busy, i <= GAP);
         tick();
      end
      chk("dis_hs_count", hs_own.size(), 1);
      cfg_arb_en = 1'b1;
      wait_hs(4, 60);
      for (int j = 1; j < 4 && j < hs_own.size(); j++) begin
         chk("en_owner", hs_own[j], 0);
         chk("en_data", hs_dat[j], 8'h81 + j);
      end

      // Random traffic against the model.
      do_reset();
      drv_mode = 2;
      repeat (4000) tick();
      drv_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART transmit path (the TX FIFO/serializer byte interface) among NREQ byte-stream requesters, e.g. RISC core console, debug monitor, boot loader.
- Grants are round-robin and held for a whole burst (up to req_last), so messages from different sources never interleave mid-packet.
- Enforces a configurable idle gap between owners, a per-burst byte cap, and a stall timeout so a stalled requester cannot lock the UART.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYC, 16, app_clk cycles of enforced idle after each burst (0 = none).
- LOCK_MAX, 255, maximum bytes per grant before forced re-arbitration (1..255).
- STALL_MAX, 64, consecutive cycles with the owner's req_valid low before the grant is revoked (1..255).

Ports:
- app_clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_arb_en  in  1  arbiter enable.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  marks the final byte of a burst.
- req_ready  out  NREQ  per-requester byte accepted.
- tx_valid  out  1  byte valid to the UART TX.
- tx_data  out  8  byte to the UART TX.
- tx_ready  in  1  UART TX can accept a byte.
- grant_id  out  $clog2(NREQ)  current or last owner index.
- busy  out  1  high in XFER or GAP.
- stall_abort  out  1  one-cycle pulse when a grant is revoked by stall timeout.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant_id=0, rr_ptr=NREQ-1 (so requester 0 has first priority), byte_cnt=0, gap_cnt=0, stall_cnt=0.
  - All outputs 0.
  - Reset asserted mid-burst drops the burst immediately; there is no replay.
- States: IDLE, XFER, GAP.
- IDLE:
  - If cfg_arb_en=1 and any req_valid=1, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Registered: grant_id=sel, rr_ptr=sel, byte_cnt=0, stall_cnt=0. Go to XFER.
  - Latency: req_valid rising at cycle n gives tx_valid=1 at n+1.
- XFER (combinational pass-through from the grant register):
  - tx_valid = req_valid[grant_id] & cfg_arb_en.
  - tx_data = req_data[grant_id].
  - req_ready[grant_id] = tx_ready & cfg_arb_en; all other req_ready bits = 0.
  - Handshake = tx_valid & tx_ready. Each handshake increments byte_cnt (8 bits) and clears stall_cnt.
  - Exit to GAP after a handshake with req_last[grant_id]=1, or a handshake where byte_cnt==LOCK_MAX-1.
  - Exit to GAP when req_valid[grant_id]=0 for STALL_MAX consecutive cycles; stall_abort pulses in the transition cycle.
  - Exit to GAP when cfg_arb_en=0. A handshake cannot occur in that cycle because tx_valid is gated.
  - Simultaneous last/LOCK_MAX/stall conditions all produce a single transition and a single GAP; stall_abort pulses only if no handshake occurred in that cycle.
  - Non-owner req_valid is ignored; it must not change tx_*.
- GAP:
  - tx_valid=0, req_ready=0.
  - gap_cnt counts up from 0; the state returns to IDLE once gap_cnt==GAP_CYC-1.
  - With GAP_CYC=0, XFER goes directly to IDLE.
- Outputs:
  - busy = (state != IDLE).
  - grant_id holds its value in GAP and IDLE until the next grant.
- Arithmetic:
  - Counters saturate at their compare value and never wrap.
  - The rr_ptr increment wraps modulo NREQ; non-power-of-2 NREQ is handled explicitly.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,3,0,...
- tx_valid may drop without a handshake if the owner drops req_valid; the UART TX must tolerate this.

Test Plan:
- Single source: req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready=1, GAP_CYC=16 -> tx_data sequence 41,42,43 on consecutive cycles starting 1 cycle after req_valid; busy drops 16 cycles after the last handshake.
- Round-robin: all 4 requesters continuously valid with 2-byte bursts -> grant_id order 0,1,2,3,0; no bytes interleave inside a burst.
- Lock cap: LOCK_MAX=4, req2 sends 10 bytes with no last -> bytes delivered as 4, then GAP and re-arbitration (req2 re-wins only if alone), 4, then 2.
- Stall abort: req1 granted, drops valid after 1 byte for 64 cycles -> stall_abort pulses once, enters GAP, and a pending req3 is granted after the gap.
- Backpressure: tx_ready held 0 for 20 cycles mid-burst -> tx_data stable, req_ready=0, no stall abort (owner valid remains high), burst resumes intact.
- Reset/enable: assert reset_n=0 mid-burst -> all outputs 0 immediately; separately, drop cfg_arb_en mid-burst -> no further handshakes, GAP then IDLE, and no new grant until re-enabled.
